// File: rtl/mod_add_sub_unit_if.sv
// Request/result bundle for the sequential modular adder/subtractor.
// The master drives the request side; the unit (slave) drives busy/done/result.
interface mod_add_sub_unit_if #(
   parameter int K = 8
);
   logic         i_start;
   logic         i_op;
   logic [K-1:0] i_A;
   logic [K-1:0] i_B;
   logic [K-1:0] i_M;
   logic         o_busy;
   logic         o_done;
   logic [K-1:0] o_R;

   modport master (
      output i_start, i_op, i_A, i_B, i_M,
      input  o_busy, o_done, o_R
   );

   modport slave (
      input  i_start, i_op, i_A, i_B, i_M,
      output o_busy, o_done, o_R
   );
endinterface

// File: rtl/mod_add_sub_unit.sv
// Sequential (A +/- B) mod M: one shared K-bit adder runs a forward pass (S1)
// and a correction pass by M (S2), giving a fixed three-edge latency.
module mod_add_sub_unit #(
   parameter int K = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mod_add_sub_unit_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2
   } state_t;

   state_t       state;
   state_t       state_next;

   logic [K-1:0] a_q;
   logic [K-1:0] b_q;
   logic [K-1:0] m_q;
   logic [K-1:0] p_q;
   logic [K-1:0] r_q;
   logic         op_q;
   logic         c1_q;
   logic         done_q;

   logic [K-1:0] add_x;
   logic [K-1:0] add_y;
   logic         add_cin;
   logic [K-1:0] add_sum;
   logic         add_cout;
   logic [K-1:0] result;

   // S1 feeds A with B (or ~B + 1); S2 feeds P with ~M + 1 (after add) or M (after sub).
   always_comb begin
      add_x   = a_q;
      add_y   = op_q ? ~b_q : b_q;
      add_cin = op_q;
      if (state == S2) begin
         add_x   = p_q;
         add_y   = op_q ? m_q : ~m_q;
         add_cin = ~op_q;
      end
   end

   assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{K{1'b0}}, add_cin};

   // An add overflowing 2^K (c1) must be reduced even when P - M itself borrows.
   always_comb begin
      result = p_q;
      if (op_q) begin
         result = c1_q ? p_q : add_sum;
      end else begin
         result = (c1_q | add_cout) ? add_sum : p_q;
      end
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = bus.i_start ? S1 : IDLE;
         S1:      state_next = S2;
         S2:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         op_q   <= 1'b0;
         p_q    <= '0;
         c1_q   <= 1'b0;
         r_q    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  a_q  <= bus.i_A;
                  b_q  <= bus.i_B;
                  m_q  <= bus.i_M;
                  op_q <= bus.i_op;
               end
            end
            S1: begin
               p_q  <= add_sum;
               c1_q <= add_cout;
            end
            S2: begin
               r_q    <= result;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy = (state == S1) || (state == S2);
   assign bus.o_done = done_q;
   assign bus.o_R    = r_q;

endmodule

// File: doc/mod_add_sub_unit.md
# mod_add_sub_unit

Sequential modular adder/subtractor. It computes (A + B) mod M or (A − B) mod M for K-bit operands, with a start/done handshake. A single K-bit carry-lookahead adder path is time-shared over two compute cycles: the forward operation, then a conditional correction by M (subtract M after an add, restore +M after a borrow). It sits beside the Montgomery multiplier datapath and serves modular additions and subtractions in the exponentiation and point-arithmetic control flow.

## Interface
- K, 8, operand/modulus width in bits (K ≥ 2)
- i_clk  in  1  clock, rising-edge
- i_rst_n  in  1  reset; one clock, asynchronous assert, active-low
- i_start  in  1  request pulse; accepted only in IDLE
- i_op  in  1  0 = modular add, 1 = modular subtract
- i_A  in  K  operand A; precondition A < M
- i_B  in  K  operand B; precondition B < M
- i_M  in  K  modulus; precondition M > 0
- o_busy  out  1  high in S1 and S2
- o_done  out  1  one-cycle pulse when o_R is updated
- o_R  out  K  result register; holds its value until the next o_done

## Operation
- States: IDLE → S1 → S2 → IDLE. No other states. The state register is encoded so that unused codes return to IDLE.
- IDLE: when i_start = 1, latch A, B, M and op into internal registers and go to S1. Inputs are ignored after the latch.
- S1, forward pass through the shared adder:
  - add: {c1, P} = A + B + 0
  - sub: {c1, P} = A + ~B + 1
  - Store P (K bits) and c1. Go to S2.
- S2, correction pass through the same adder:
  - add: {c2, Q} = P + ~M + 1. Result = Q if (c1 | c2), else P. This covers both true sum ≥ 2^K and sum ≥ M.
  - sub: {c2, Q} = P + M. Result = P if c1 = 1 (no borrow), else Q (low K bits; c2 discarded).
  - Write the result to o_R, pulse o_done, go to IDLE.
- If the preconditions are violated, o_R is exactly the formula above truncated to K bits. No error flag.
- i_start while busy (S1/S2) is ignored. It is not queued.
- i_op, i_A, i_B, i_M may change freely while busy without affecting the operation in flight.

## Timing
- Reset values: state = IDLE, o_busy = 0, o_done = 0, o_R = 0, and all internal operand/intermediate registers = 0.
- Reset mid-operation aborts immediately (asynchronous). No o_done is produced for the aborted request. o_R is cleared to 0.
- Let edge n be the rising edge that samples i_start = 1 in IDLE:
  - o_busy = 1 after edges n and n+1.
  - o_done = 1 and the new o_R appear after edge n+2, for exactly one cycle.
  - o_busy = 0 in the o_done cycle.
- Fixed latency is 3 edges for both ops, independent of whether the correction is applied.
- Back-to-back: i_start held high during the o_done cycle is accepted at that edge. Throughput is one result per 3 cycles.
- o_done is registered. o_R is registered and stable whenever o_done = 1.

## Test plan
- K=8, M=251, add, A=200, B=100 → o_R=49 (c1=1 path), o_done exactly 3 edges after start.
- K=8, M=251, add, A=151, B=100 → 0; add A=10, B=20 → 30 (no correction).
- K=8, M=251, sub, A=5, B=10 → 246 (restore path); sub A=10, B=5 → 5; sub A=77, B=77 → 0.
- Start held high continuously with alternating ops: results appear every 3 cycles. A start pulse during S1 is ignored, and o_R is unchanged by the changed inputs.
- Assert i_rst_n=0 in S2 of an add (200+100, M=251) → o_R=0, o_busy=0, no o_done. A new request after release completes normally.
- K=16 random sweep: 10k vectors with A, B < M → o_R matches the reference model (A±B) mod M. Exhaustive K=4 over all valid (A, B, M, op).
